// File: rtl/tlb_lookup_arbiter.sv
// Arbitrates the shared JTLB search port between ITLB and DTLB miss requests.
// Round-robin grant, fixed-latency lookup with write-retry, registered response to the winner.
module tlb_lookup_arbiter #(
    parameter int LOOKUP_LAT = 1,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             itlb_req,
    input  logic [31:0]      itlb_vaddr,
    output logic             itlb_ack,
    output logic             itlb_resp_valid,
    input  logic             dtlb_req,
    input  logic [31:0]      dtlb_vaddr,
    output logic             dtlb_ack,
    output logic             dtlb_resp_valid,
    input  logic [7:0]       cp0_asid,
    input  logic             tlb_write_busy,
    input  logic             flush,
    output logic             jtlb_search_valid,
    output logic [18:0]      jtlb_vpn2,
    output logic             jtlb_odd,
    output logic [7:0]       jtlb_asid,
    input  logic             jtlb_found,
    input  logic [IDX_W-1:0] jtlb_index,
    input  logic [19:0]      jtlb_pfn,
    input  logic [2:0]       jtlb_c,
    input  logic             jtlb_d,
    input  logic             jtlb_v,
    output logic             resp_found,
    output logic [IDX_W-1:0] resp_index,
    output logic [19:0]      resp_pfn,
    output logic [2:0]       resp_c,
    output logic             resp_d,
    output logic             resp_v,
    output logic [7:0]       resp_asid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(LOOKUP_LAT - 1);

    state_t     state;
    state_t     state_next;
    logic       rr_d_first;
    logic       owner_d;
    logic [1:0] lat_cnt;
    logic       grant_i;
    logic       grant_d;
    logic       lookup_done;

    // Grants are only issued from IDLE; on a tie the pointer picks the side.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE && !flush && !tlb_write_busy && !reset) begin
            if (dtlb_req && (!itlb_req || rr_d_first)) begin
                grant_d = 1'b1;
            end else if (itlb_req) begin
                grant_i = 1'b1;
            end
        end
    end

    assign lookup_done = (state == LOOKUP) && !flush && !tlb_write_busy && (lat_cnt == LAST_CNT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_i || grant_d) state_next = LOOKUP;
            LOOKUP:  if (lookup_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A TLB write during the lookup makes the result stale, so the count restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt <= 2'd0;
        end else if (flush || grant_i || grant_d) begin
            lat_cnt <= 2'd0;
        end else if (state == LOOKUP) begin
            if (tlb_write_busy || lookup_done) begin
                lat_cnt <= 2'd0;
            end else begin
                lat_cnt <= lat_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_d_first <= 1'b1;
            owner_d    <= 1'b0;
            jtlb_vpn2  <= 19'd0;
            jtlb_odd   <= 1'b0;
            jtlb_asid  <= 8'd0;
        end else if (grant_d) begin
            rr_d_first <= 1'b0;
            owner_d    <= 1'b1;
            jtlb_vpn2  <= dtlb_vaddr[31:13];
            jtlb_odd   <= dtlb_vaddr[12];
            jtlb_asid  <= cp0_asid;
        end else if (grant_i) begin
            rr_d_first <= 1'b1;
            owner_d    <= 1'b0;
            jtlb_vpn2  <= itlb_vaddr[31:13];
            jtlb_odd   <= itlb_vaddr[12];
            jtlb_asid  <= cp0_asid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_found <= 1'b0;
            resp_index <= '0;
            resp_pfn   <= 20'd0;
            resp_c     <= 3'd0;
            resp_d     <= 1'b0;
            resp_v     <= 1'b0;
            resp_asid  <= 8'd0;
        end else if (lookup_done) begin
            resp_found <= jtlb_found;
            resp_index <= jtlb_index;
            resp_pfn   <= jtlb_pfn;
            resp_c     <= jtlb_c;
            resp_d     <= jtlb_d;
            resp_v     <= jtlb_v;
            resp_asid  <= jtlb_asid;
        end
    end

    assign itlb_ack          = grant_i;
    assign dtlb_ack          = grant_d;
    assign jtlb_search_valid = (state == LOOKUP);
    assign itlb_resp_valid   = (state == RESP) && !flush && !owner_d;
    assign dtlb_resp_valid   = (state == RESP) && !flush && owner_d;

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Directed bench for tlb_lookup_arbiter: one instance at LOOKUP_LAT=1, one at LOOKUP_LAT=3.
module tb_tlb_lookup_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        itlb_req, dtlb_req, itlb_req3, dtlb_req3;
    logic [31:0] itlb_vaddr, dtlb_vaddr;
    logic [7:0]  cp0_asid;
    logic        tlb_write_busy, flush;
    logic        jtlb_found, jtlb_d, jtlb_v;
    logic [3:0]  jtlb_index;
    logic [19:0] jtlb_pfn;
    logic [2:0]  jtlb_c;

    logic        itlb_ack, dtlb_ack, itlb_resp_valid, dtlb_resp_valid, jtlb_search_valid;
    logic [18:0] jtlb_vpn2;
    logic        jtlb_odd;
    logic [7:0]  jtlb_asid, resp_asid;
    logic        resp_found, resp_d, resp_v;
    logic [3:0]  resp_index;
    logic [19:0] resp_pfn;
    logic [2:0]  resp_c;

    logic        itlb_ack3, dtlb_ack3, itlb_resp_valid3, dtlb_resp_valid3, jtlb_search_valid3;
    logic [18:0] jtlb_vpn2_3;
    logic        jtlb_odd3;
    logic [7:0]  jtlb_asid3, resp_asid3;
    logic        resp_found3, resp_d3, resp_v3;
    logic [3:0]  resp_index3;
    logic [19:0] resp_pfn3;
    logic [2:0]  resp_c3;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    tlb_lookup_arbiter #(.LOOKUP_LAT(1), .IDX_W(4)) dut (
        .clk(clk), .reset(reset),
        .itlb_req(itlb_req), .itlb_vaddr(itlb_vaddr), .itlb_ack(itlb_ack), .itlb_resp_valid(itlb_resp_valid),
        .dtlb_req(dtlb_req), .dtlb_vaddr(dtlb_vaddr), .dtlb_ack(dtlb_ack), .dtlb_resp_valid(dtlb_resp_valid),
        .cp0_asid(cp0_asid), .tlb_write_busy(tlb_write_busy), .flush(flush),
        .jtlb_search_valid(jtlb_search_valid), .jtlb_vpn2(jtlb_vpn2), .jtlb_odd(jtlb_odd), .jtlb_asid(jtlb_asid),
        .jtlb_found(jtlb_found), .jtlb_index(jtlb_index), .jtlb_pfn(jtlb_pfn), .jtlb_c(jtlb_c),
        .jtlb_d(jtlb_d), .jtlb_v(jtlb_v),
        .resp_found(resp_found), .resp_index(resp_index), .resp_pfn(resp_pfn), .resp_c(resp_c),
        .resp_d(resp_d), .resp_v(resp_v), .resp_asid(resp_asid)
    );

    tlb_lookup_arbiter #(.LOOKUP_LAT(3), .IDX_W(4)) dut3 (
        .clk(clk), .reset(reset),
        .itlb_req(itlb_req3), .itlb_vaddr(itlb_vaddr), .itlb_ack(itlb_ack3), .itlb_resp_valid(itlb_resp_valid3),
        .dtlb_req(dtlb_req3), .dtlb_vaddr(dtlb_vaddr), .dtlb_ack(dtlb_ack3), .dtlb_resp_valid(dtlb_resp_valid3),
        .cp0_asid(cp0_asid), .tlb_write_busy(tlb_write_busy), .flush(flush),
        .jtlb_search_valid(jtlb_search_valid3), .jtlb_vpn2(jtlb_vpn2_3), .jtlb_odd(jtlb_odd3), .jtlb_asid(jtlb_asid3),
        .jtlb_found(jtlb_found), .jtlb_index(jtlb_index), .jtlb_pfn(jtlb_pfn), .jtlb_c(jtlb_c),
        .jtlb_d(jtlb_d), .jtlb_v(jtlb_v),
        .resp_found(resp_found3), .resp_index(resp_index3), .resp_pfn(resp_pfn3), .resp_c(resp_c3),
        .resp_d(resp_d3), .resp_v(resp_v3), .resp_asid(resp_asid3)
    );

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({itlb_ack, dtlb_ack, itlb_resp_valid, dtlb_resp_valid, jtlb_search_valid} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_strobes got=%b exp=00000",
                     {itlb_ack, dtlb_ack, itlb_resp_valid, dtlb_resp_valid, jtlb_search_valid});
        end
        tests_run++;
        if ({jtlb_vpn2, jtlb_odd, jtlb_asid, resp_found, resp_index, resp_pfn, resp_asid} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_regs vpn2=%h asid=%h found=%b idx=%h pfn=%h exp=all 0",
                     jtlb_vpn2, jtlb_asid, resp_found, resp_index, resp_pfn);
        end
    endtask

    task automatic test_itlb_hit();
        step();
        itlb_req = 1'b1; itlb_vaddr = 32'hBFC0_1000; cp0_asid = 8'h12;
        #1;
        tests_run++;
        if (itlb_ack !== 1'b1 || dtlb_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hit_ack i=%b d=%b exp i=1 d=0", itlb_ack, dtlb_ack);
        end
        step();
        itlb_req = 1'b0; cp0_asid = 8'h99;
        jtlb_found = 1'b1; jtlb_index = 4'd3; jtlb_pfn = 20'h1FC01; jtlb_c = 3'd3; jtlb_d = 1'b1; jtlb_v = 1'b1;
        #1;
        tests_run++;
        if (jtlb_search_valid !== 1'b1 || jtlb_vpn2 !== 19'h5FE00 || jtlb_odd !== 1'b1 || jtlb_asid !== 8'h12) begin
            tests_failed++;
            $display("[TB] FAIL hit_search sv=%b vpn2=%h odd=%b asid=%h exp sv=1 vpn2=5fe00 odd=1 asid=12",
                     jtlb_search_valid, jtlb_vpn2, jtlb_odd, jtlb_asid);
        end
        step();
        #1;
        tests_run++;
        if (itlb_resp_valid !== 1'b1 || dtlb_resp_valid !== 1'b0 || resp_found !== 1'b1 || resp_index !== 4'd3
            || resp_pfn !== 20'h1FC01 || resp_c !== 3'd3 || resp_asid !== 8'h12) begin
            tests_failed++;
            $display("[TB] FAIL hit_resp iv=%b dv=%b found=%b idx=%0d pfn=%h c=%0d asid=%h exp 1 0 1 3 1fc01 3 12",
                     itlb_resp_valid, dtlb_resp_valid, resp_found, resp_index, resp_pfn, resp_c, resp_asid);
        end
        jtlb_found = 1'b0; jtlb_index = 4'd0;
        step();
        #1;
        tests_run++;
        if (itlb_resp_valid !== 1'b0 || resp_found !== 1'b1 || resp_index !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL hit_hold iv=%b found=%b idx=%0d exp iv=0 found=1 idx=3",
                     itlb_resp_valid, resp_found, resp_index);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        step();
        itlb_req = 1'b1; dtlb_req = 1'b1; itlb_vaddr = 32'h0040_0000; dtlb_vaddr = 32'h1000_3000;
        #1;
        tests_run++;
        if (dtlb_ack !== 1'b1 || itlb_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rr_first d=%b i=%b exp d=1 i=0", dtlb_ack, itlb_ack);
        end
        step();
        dtlb_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            tests_run++;
            if (itlb_ack !== (c == 3)) begin
                tests_failed++;
                $display("[TB] FAIL rr_second_cycle%0d i_ack=%b exp=%b", c, itlb_ack, (c == 3));
            end
            if (c == 2) begin
                tests_run++;
                if (dtlb_resp_valid !== 1'b1 || itlb_resp_valid !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_d_resp dv=%b iv=%b exp dv=1 iv=0", dtlb_resp_valid, itlb_resp_valid);
                end
            end
            step();
        end
        itlb_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_write_retry();
        step();
        dtlb_req = 1'b1; dtlb_vaddr = 32'h2000_4000;
        #1;
        tests_run++;
        if (dtlb_ack !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL retry_ack got=%b exp=1", dtlb_ack);
        end
        step();
        dtlb_req = 1'b0; tlb_write_busy = 1'b1;
        step();
        tlb_write_busy = 1'b0;
        #1;
        tests_run++;
        if (dtlb_resp_valid !== 1'b0 || jtlb_search_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL retry_t2 dv=%b sv=%b exp dv=0 sv=1", dtlb_resp_valid, jtlb_search_valid);
        end
        step();
        #1;
        tests_run++;
        if (dtlb_resp_valid !== 1'b1 || itlb_resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL retry_t3 dv=%b iv=%b exp dv=1 iv=0", dtlb_resp_valid, itlb_resp_valid);
        end
        step();
    endtask

    task automatic test_flush();
        step();
        itlb_req = 1'b1; itlb_vaddr = 32'h0000_5000;
        step();
        itlb_req = 1'b0; flush = 1'b1;
        #1;
        tests_run++;
        if (itlb_ack !== 1'b0 || jtlb_search_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_lookup ack=%b sv=%b exp ack=0 sv=1", itlb_ack, jtlb_search_valid);
        end
        step();
        flush = 1'b0; itlb_req = 1'b1;
        #1;
        tests_run++;
        if (itlb_resp_valid !== 1'b0 || jtlb_search_valid !== 1'b0 || itlb_ack !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_regrant iv=%b sv=%b ack=%b exp iv=0 sv=0 ack=1",
                     itlb_resp_valid, jtlb_search_valid, itlb_ack);
        end
        step();
        itlb_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_miss_lat3();
        step();
        dtlb_req3 = 1'b1; dtlb_vaddr = 32'h7FFF_E000; cp0_asid = 8'h5A;
        jtlb_found = 1'b0; jtlb_index = 4'd0;
        #1;
        tests_run++;
        if (dtlb_ack3 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL lat3_ack got=%b exp=1", dtlb_ack3);
        end
        step();
        dtlb_req3 = 1'b0; cp0_asid = 8'h77;
        for (int c = 1; c <= 4; c++) begin
            #1;
            tests_run++;
            if (dtlb_resp_valid3 !== (c == 4) || jtlb_search_valid3 !== (c <= 3)) begin
                tests_failed++;
                $display("[TB] FAIL lat3_cycle%0d dv=%b sv=%b exp dv=%b sv=%b",
                         c, dtlb_resp_valid3, jtlb_search_valid3, (c == 4), (c <= 3));
            end
            if (c == 4) begin
                tests_run++;
                if (resp_found3 !== 1'b0 || resp_asid3 !== 8'h5A) begin
                    tests_failed++;
                    $display("[TB] FAIL lat3_resp found=%b asid=%h exp found=0 asid=5a", resp_found3, resp_asid3);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid_lookup();
        jtlb_found = 1'b1;
        step();
        dtlb_req = 1'b1; dtlb_vaddr = 32'h3000_1000;
        step();
        dtlb_req = 1'b0;
        step();
        step();
        itlb_req = 1'b1; itlb_vaddr = 32'h8000_3000;
        step();
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({itlb_ack, dtlb_ack, itlb_resp_valid, dtlb_resp_valid, jtlb_search_valid} !== 5'b0
            || jtlb_vpn2 !== 19'd0 || resp_found !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid strobes=%b vpn2=%h found=%b exp all 0",
                     {itlb_ack, dtlb_ack, itlb_resp_valid, dtlb_resp_valid, jtlb_search_valid},
                     jtlb_vpn2, resp_found);
        end
        itlb_req = 1'b0;
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            #1;
            tests_run++;
            if (itlb_resp_valid !== 1'b0 || dtlb_resp_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_late_cycle%0d iv=%b dv=%b exp 0 0", c, itlb_resp_valid, dtlb_resp_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        itlb_req = 1'b0; dtlb_req = 1'b0; itlb_req3 = 1'b0; dtlb_req3 = 1'b0;
        itlb_vaddr = '0; dtlb_vaddr = '0; cp0_asid = '0;
        tlb_write_busy = 1'b0; flush = 1'b0;
        jtlb_found = 1'b0; jtlb_index = '0; jtlb_pfn = '0; jtlb_c = '0; jtlb_d = 1'b0; jtlb_v = 1'b0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_itlb_hit();
        test_round_robin();
        test_write_retry();
        test_flush();
        test_miss_lat3();
        test_reset_mid_lookup();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
